// File: rtl/vec_result_packer_pkg.sv
// Shared SIMD writeback types: pack modes, default lane geometry and the
// signed-saturating narrow used by the ALU, control unit and result packer.
package vec_pkg;

  localparam int DEF_NUM_LANES = 16;
  localparam int DEF_LANE_W    = 32;
  localparam int DEF_HALF_W    = DEF_LANE_W / 2;

  typedef enum logic [1:0] {
    PM_FULL  = 2'b00,
    PM_TRUNC = 2'b01,
    PM_SAT   = 2'b10
  } pack_mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } pk_state_t;

  // Encoding 2'b11 is reserved and behaves as full width.
  function automatic pack_mode_t decode_mode(input logic [1:0] m);
    pack_mode_t r;
    case (m)
      2'b01:   r = PM_TRUNC;
      2'b10:   r = PM_SAT;
      default: r = PM_FULL;
    endcase
    return r;
  endfunction

  function automatic logic [DEF_HALF_W-1:0] sat_narrow(input logic [DEF_LANE_W-1:0] v);
    logic [DEF_HALF_W:0]   upper;
    logic [DEF_HALF_W-1:0] r;
    upper = v[DEF_LANE_W-1:DEF_HALF_W-1];
    if ((&upper) || !(|upper)) r = v[DEF_HALF_W-1:0];
    else if (v[DEF_LANE_W-1])  r = {1'b1, {(DEF_HALF_W-1){1'b0}}};
    else                       r = {1'b0, {(DEF_HALF_W-1){1'b1}}};
    return r;
  endfunction

endpackage

// File: rtl/vec_result_packer_lane_narrow.sv
// One lane of the result packer: combinational truncate or signed saturate
// from LANE_W down to LANE_W/2 bits.
module lane_narrow
  import vec_pkg::*;
#(
  parameter int LANE_W = DEF_LANE_W
) (
  input  logic [LANE_W-1:0]   lane_i,
  input  pack_mode_t          mode_i,
  output logic [LANE_W/2-1:0] narrow_o
);

  localparam int HALF_W = LANE_W / 2;

  logic [HALF_W:0]   upper;
  logic              ovf;
  logic [HALF_W-1:0] sat;

  // The value fits when the dropped bits plus the new sign bit are all copies of the sign.
  always_comb begin
    upper = lane_i[LANE_W-1:HALF_W-1];
    ovf   = !((&upper) || !(|upper));
    if (!ovf)               sat = lane_i[HALF_W-1:0];
    else if (lane_i[LANE_W-1]) sat = {1'b1, {(HALF_W-1){1'b0}}};
    else                    sat = {1'b0, {(HALF_W-1){1'b1}}};
    narrow_o = (mode_i == PM_SAT) ? sat : lane_i[HALF_W-1:0];
  end

endmodule

// File: rtl/vec_result_packer.sv
// SIMD writeback packer: captures one lane vector, optionally narrows each lane,
// packs lane 0 at the LSB and streams the result as BUS_W-bit beats.
module vec_result_packer
  import vec_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int LANE_W    = DEF_LANE_W,
  parameter int BUS_W     = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_LANES-1:0][LANE_W-1:0]  in_lanes,
  input  logic [1:0]                        in_mode,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [BUS_W-1:0]                  out_data,
  output logic                              out_last,
  output logic                              busy
);

  localparam int HALF_W    = LANE_W / 2;
  localparam int PACK_W    = NUM_LANES * LANE_W;
  localparam int NB_FULL   = PACK_W / BUS_W;
  localparam int NB_NARROW = NB_FULL / 2;
  localparam int BEAT_W    = (NB_FULL > 1) ? $clog2(NB_FULL) : 1;

  localparam logic [BEAT_W-1:0] LAST_FULL   = BEAT_W'(NB_FULL - 1);
  localparam logic [BEAT_W-1:0] LAST_NARROW = BEAT_W'(NB_NARROW - 1);

  pk_state_t          state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  pack_mode_t         mode_q, mode_d;
  logic [PACK_W-1:0]  pack_q, pack_d;

  pack_mode_t                            cap_mode;
  logic [NUM_LANES-1:0][HALF_W-1:0]      narrowed;
  logic [PACK_W-1:0]                     packed_narrow;
  logic [BEAT_W-1:0]                     last_idx;
  logic                                  last_beat;
  logic                                  accept;

  assign cap_mode = decode_mode(in_mode);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_narrow #(.LANE_W(LANE_W)) u_narrow (
      .lane_i   (in_lanes[g]),
      .mode_i   (cap_mode),
      .narrow_o (narrowed[g])
    );
  end

  assign packed_narrow = {{(PACK_W/2){1'b0}}, narrowed};

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; valid never depends on ready, and a stalled beat holds data and last.
  // in_ready also rises on the final beat handshake so vectors stream back to back.
  always_comb begin
    last_idx  = (mode_q == PM_FULL) ? LAST_FULL : LAST_NARROW;
    out_valid = (state_q == ST_SEND);
    busy      = (state_q == ST_SEND);
    last_beat = out_valid && (beat_q == last_idx);
    out_last  = last_beat;
    out_data  = out_valid ? pack_q[beat_q*BUS_W +: BUS_W] : '0;
    in_ready  = ((state_q == ST_IDLE) || (last_beat && out_ready)) && !rst;
    accept    = in_valid && in_ready;
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    mode_d  = mode_q;
    pack_d  = pack_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SEND;
          beat_d  = '0;
          mode_d  = cap_mode;
          pack_d  = (cap_mode == PM_FULL) ? in_lanes : packed_narrow;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (last_beat) begin
            if (accept) begin
              beat_d = '0;
              mode_d = cap_mode;
              pack_d = (cap_mode == PM_FULL) ? in_lanes : packed_narrow;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      mode_q  <= PM_FULL;
      pack_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      mode_q  <= mode_d;
      pack_q  <= pack_d;
    end
  end

endmodule

// File: tb/tb_vec_result_packer.sv
// Directed bench for vec_result_packer: hand-computed beats pushed into an
// expected queue and compared as the DUT streams them out.
module tb_vec_result_packer;

  localparam int NL = 16;
  localparam int LW = 32;
  localparam int BW = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [NL-1:0][LW-1:0]  in_lanes;
  logic [1:0]             in_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [BW-1:0]          out_data;
  logic                   out_last;
  logic                   busy;

  logic [BW:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vec_result_packer #(.NUM_LANES(NL), .LANE_W(LW), .BUS_W(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_lanes  (in_lanes),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [BW-1:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  task automatic push_full(input logic [NL-1:0][LW-1:0] v);
    for (int k = 0; k < NL; k++) push_beat(v[k], k == NL - 1);
  endtask

  function automatic logic [NL-1:0][LW-1:0] sat_vec();
    logic [NL-1:0][LW-1:0] v;
    v    = '0;
    v[0] = 32'h0001_0000;
    v[1] = 32'hFFFF_0000;
    v[2] = 32'h0000_1234;
    v[3] = 32'hFFFF_8000;
    v[4] = 32'hFFFF_7FFF;
    v[5] = 32'h0000_7FFF;
    v[6] = 32'h0000_8000;
    v[7] = 32'hFFFF_FFFF;
    return v;
  endfunction

  task automatic push_sat_beats();
    push_beat(32'h8000_7FFF, 1'b0);
    push_beat(32'h8000_1234, 1'b0);
    push_beat(32'h7FFF_8000, 1'b0);
    push_beat(32'hFFFF_7FFF, 1'b0);
    for (int k = 4; k < 8; k++) push_beat(32'h0, k == 7);
  endtask

  task automatic start_vec(input logic [NL-1:0][LW-1:0] v, input logic [1:0] m, input string tag);
    in_lanes = v;
    in_mode  = m;
    in_valid = 1'b1;
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    check({tag, "_latency"}, out_valid, 1);
  endtask

  // Consume expected beats; in_ready is only allowed on a last beat being taken.
  task automatic drain(input bit toggle, input bit no_gap, input int budget);
    int            n = 0;
    bit            stalled = 1'b0;
    bit            acc;
    logic [BW-1:0] held = '0;
    logic [BW:0]   e;
    while (exp_q.size() > 0 && n < budget) begin
      out_ready = toggle ? ~n[0] : 1'b1;
      #1;
      acc = in_valid && in_ready;
      if (no_gap) check("no_gap", out_valid, 1);
      if (out_valid) begin
        e = exp_q[0];
        if (stalled) check("stall_hold", out_data, held);
        check("in_ready_send", in_ready, e[BW] & out_ready);
        if (out_ready) begin
          e = exp_q.pop_front();
          check("beat_data", out_data, e[BW-1:0]);
          check("beat_last", out_last, e[BW]);
          stalled = 1'b0;
        end else begin
          held    = out_data;
          stalled = 1'b1;
        end
      end
      tick();
      n++;
      if (acc) in_valid = 1'b0;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    logic [NL-1:0][LW-1:0] v;
    logic [NL-1:0][LW-1:0] vb;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_lanes  = '0;
    in_mode   = 2'b00;
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", in_ready, 1);

    // full width, 16 beats
    for (int i = 0; i < NL; i++) v[i] = 32'h1000_0000 + i;
    out_ready = 1'b1;
    start_vec(v, 2'b00, "t1");
    push_full(v);
    drain(1'b0, 1'b1, 100);
    check("t1_idle_busy", busy, 0);

    // signed saturation, 8 beats
    start_vec(sat_vec(), 2'b10, "t2");
    push_sat_beats();
    drain(1'b0, 1'b1, 100);

    // truncation
    v    = '0;
    v[0] = 32'h1234_ABCD;
    v[1] = 32'h0000_0001;
    v[2] = 32'hFFFF_8000;
    v[3] = 32'h0001_0000;
    start_vec(v, 2'b01, "t3");
    push_beat(32'h0001_ABCD, 1'b0);
    push_beat(32'h0000_8000, 1'b0);
    for (int k = 2; k < 8; k++) push_beat(32'h0, k == 7);
    drain(1'b0, 1'b1, 100);

    // reserved mode 11 behaves as full, with out_ready toggling
    for (int i = 0; i < NL; i++) v[i] = 32'hA5A5_0000 + i * 32'h11;
    start_vec(v, 2'b11, "t4");
    push_full(v);
    drain(1'b1, 1'b0, 200);
    check("t4_idle_busy", busy, 0);

    // back-to-back: B offered (with a different mode) while A streams
    for (int i = 0; i < NL; i++) v[i]  = 32'h7777_0000 | i;
    for (int i = 0; i < NL; i++) vb[i] = 32'hB000_0000 + i * 3;
    out_ready = 1'b1;
    start_vec(v, 2'b01, "t5");
    in_lanes = vb;
    in_mode  = 2'b00;
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) push_beat({16'(2*k+1), 16'(2*k)}, k == 7);
    push_full(vb);
    drain(1'b0, 1'b1, 100);
    check("t5_idle_busy", busy, 0);

    // reset in the middle of a transfer
    for (int i = 0; i < NL; i++) v[i] = 32'hC000_0000 + i * 32'h101;
    start_vec(v, 2'b00, "t6");
    for (int k = 0; k < 5; k++) push_beat(v[k], 1'b0);
    drain(1'b0, 1'b1, 100);
    check("t6_beat5_data", out_data, 32'hC000_0505);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_in_ready", in_ready, 1);
    check("t6_rst_out_data", out_data, 0);
    start_vec(sat_vec(), 2'b10, "t6b");
    push_sat_beats();
    drain(1'b0, 1'b1, 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
